// File: rtl/issue_stage_pkg.sv
// issue_stage_pkg: shared unit encodings, widths and opcode constants for the issue stage
package issue_stage_pkg;

    localparam int ISS_DATA_W = 32;
    localparam int ISS_ADDR_W = 5;

    typedef enum logic [1:0] {
        FU_ALU   = 2'd0,
        FU_SHIFT = 2'd1,
        FU_MEM   = 2'd2
    } fu_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_OR  = 6'h25;

    // Memory ops take priority over the shift select; everything else goes to the ALU
    function automatic fu_e unit_sel(input logic readmem, input logic writemem, input logic selalushift);
        return (readmem | writemem) ? FU_MEM : selalushift ? FU_SHIFT : FU_ALU;
    endfunction

endpackage

// File: rtl/issue_stage_scoreboard.sv
// issue_scoreboard: pending-write vector with set/clear ports and three async lookups
module issue_scoreboard
    import issue_stage_pkg::*;
#(
    parameter int ADDR_W = ISS_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_set_en,
    input  logic [ADDR_W-1:0] i_set_addr,
    input  logic              i_clr_en,
    input  logic [ADDR_W-1:0] i_clr_addr,
    input  logic [ADDR_W-1:0] i_qa_addr,
    input  logic [ADDR_W-1:0] i_qb_addr,
    input  logic [ADDR_W-1:0] i_qc_addr,
    output logic              o_qa,
    output logic              o_qb,
    output logic              o_qc
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_next;

    // Clear first so a set of the same register in the same cycle wins; r0 never pends
    always_comb begin
        w_next = r_pending;
        if (i_clr_en) w_next[i_clr_addr] = 1'b0;
        if (i_set_en) w_next[i_set_addr] = 1'b1;
        w_next[0] = 1'b0;
    end

    // Pending vector state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_pending <= '0;
        else        r_pending <= w_next;
    end

    assign o_qa = r_pending[i_qa_addr];
    assign o_qb = r_pending[i_qb_addr];
    assign o_qc = r_pending[i_qc_addr];

endmodule

// File: rtl/issue_stage.sv
// issue_stage: hazard check against scoreboard/busy flags and single-issue dispatch to ALU, shift or memory
module issue_stage
    import issue_stage_pkg::*;
#(
    parameter int DATA_W = ISS_DATA_W,
    parameter int ADDR_W = ISS_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [5:0]        i_id_op,
    input  logic [5:0]        i_id_funct,
    input  logic [ADDR_W-1:0] i_id_addra,
    input  logic [ADDR_W-1:0] i_id_addrb,
    input  logic [ADDR_W-1:0] i_id_regdest,
    input  logic              i_id_writereg,
    input  logic              i_id_writeov,
    input  logic              i_id_selalushift,
    input  logic              i_id_selimregb,
    input  logic [2:0]        i_id_aluop,
    input  logic [1:0]        i_id_shiftop,
    input  logic              i_id_unsig,
    input  logic              i_id_readmem,
    input  logic              i_id_writemem,
    input  logic              i_id_selwsource,
    input  logic [DATA_W-1:0] i_id_imedext,
    output logic              o_iss_stall,
    output logic [ADDR_W-1:0] o_iss_reg_addra,
    output logic [ADDR_W-1:0] o_iss_reg_addrb,
    input  logic [DATA_W-1:0] i_reg_iss_dataa,
    input  logic [DATA_W-1:0] i_reg_iss_datab,
    output logic              o_iss_alu_valid,
    output logic              o_iss_shift_valid,
    output logic              o_iss_mem_valid,
    output logic [DATA_W-1:0] o_iss_dataa,
    output logic [DATA_W-1:0] o_iss_datab,
    output logic [DATA_W-1:0] o_iss_imedext,
    output logic [2:0]        o_iss_aluop,
    output logic [1:0]        o_iss_shiftop,
    output logic [ADDR_W-1:0] o_iss_regdest,
    output logic              o_iss_writereg,
    output logic              o_iss_writeov,
    output logic              o_iss_unsig,
    output logic              o_iss_readmem,
    output logic              o_iss_writemem,
    output logic              o_iss_selwsource,
    output logic              o_iss_selimregb,
    input  logic              i_alu_done,
    input  logic              i_shift_done,
    input  logic              i_mem_done,
    input  logic              i_wb_valid,
    input  logic [ADDR_W-1:0] i_wb_addr
);

    fu_e        w_unit;
    logic [2:0] w_onehot;
    logic [2:0] w_done;
    logic       w_uses_a;
    logic       w_uses_b;
    logic       w_pend_a;
    logic       w_pend_b;
    logic       w_pend_d;
    logic       w_hazard;
    logic       w_dispatch;
    logic       w_unused;
    logic [2:0] r_busy;
    logic [2:0] r_valid;

    // Opcode/funct are already decoded into the control fields; kept on the port for tracing
    assign w_unused = ^{i_id_op, i_id_funct};

    assign w_unit     = unit_sel(i_id_readmem, i_id_writemem, i_id_selalushift);
    assign w_onehot   = 3'b001 << w_unit;
    assign w_done     = {i_mem_done, i_shift_done, i_alu_done};
    assign w_uses_a   = ~i_id_selalushift;
    assign w_uses_b   = ~i_id_selimregb | i_id_writemem | i_id_selalushift;
    assign w_hazard   = (w_uses_a & w_pend_a) | (w_uses_b & w_pend_b)
                      | (i_id_writereg & w_pend_d) | r_busy[w_unit];
    assign w_dispatch = ~w_hazard;

    assign o_iss_stall       = w_hazard;
    assign o_iss_reg_addra   = i_id_addra;
    assign o_iss_reg_addrb   = i_id_addrb;
    assign o_iss_alu_valid   = r_valid[FU_ALU];
    assign o_iss_shift_valid = r_valid[FU_SHIFT];
    assign o_iss_mem_valid   = r_valid[FU_MEM];

    issue_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clock      (clock),
        .reset      (reset),
        .i_set_en   (w_dispatch & i_id_writereg & (i_id_regdest != '0)),
        .i_set_addr (i_id_regdest),
        .i_clr_en   (i_wb_valid),
        .i_clr_addr (i_wb_addr),
        .i_qa_addr  (i_id_addra),
        .i_qb_addr  (i_id_addrb),
        .i_qc_addr  (i_id_regdest),
        .o_qa       (w_pend_a),
        .o_qb       (w_pend_b),
        .o_qc       (w_pend_d)
    );

    // Busy flags: done clears, dispatch sets; a done on an idle unit is a no-op
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_busy <= '0;
        else        r_busy <= (r_busy & ~w_done) | (w_dispatch ? w_onehot : 3'b000);
    end

    // One-cycle strobe for the unit that accepted the instruction
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_valid <= '0;
        else        r_valid <= w_dispatch ? w_onehot : 3'b000;
    end

    // Payload captured on dispatch, held across stalls
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            o_iss_dataa      <= '0;
            o_iss_datab      <= '0;
            o_iss_imedext    <= '0;
            o_iss_aluop      <= '0;
            o_iss_shiftop    <= '0;
            o_iss_regdest    <= '0;
            o_iss_writereg   <= 1'b0;
            o_iss_writeov    <= 1'b0;
            o_iss_unsig      <= 1'b0;
            o_iss_readmem    <= 1'b0;
            o_iss_writemem   <= 1'b0;
            o_iss_selwsource <= 1'b0;
            o_iss_selimregb  <= 1'b0;
        end else if (w_dispatch) begin
            o_iss_dataa      <= i_reg_iss_dataa;
            o_iss_datab      <= i_reg_iss_datab;
            o_iss_imedext    <= i_id_imedext;
            o_iss_aluop      <= i_id_aluop;
            o_iss_shiftop    <= i_id_shiftop;
            o_iss_regdest    <= i_id_regdest;
            o_iss_writereg   <= i_id_writereg;
            o_iss_writeov    <= i_id_writeov;
            o_iss_unsig      <= i_id_unsig;
            o_iss_readmem    <= i_id_readmem;
            o_iss_writemem   <= i_id_writemem;
            o_iss_selwsource <= i_id_selwsource;
            o_iss_selimregb  <= i_id_selimregb;
        end
    end

endmodule

// File: tb/tb_issue_stage.sv
// tb_issue_stage: table vectors, directed hazard sequences and random traffic against a reference model
module tb_issue_stage;
    import issue_stage_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  id_op, id_funct;
    logic [4:0]  id_addra, id_addrb, id_regdest;
    logic        id_writereg, id_writeov, id_selalushift, id_selimregb;
    logic [2:0]  id_aluop;
    logic [1:0]  id_shiftop;
    logic        id_unsig, id_readmem, id_writemem, id_selwsource;
    logic [31:0] id_imedext;
    logic        iss_stall;
    logic [4:0]  iss_reg_addra, iss_reg_addrb;
    logic [31:0] reg_iss_dataa, reg_iss_datab;
    logic        iss_alu_valid, iss_shift_valid, iss_mem_valid;
    logic [31:0] iss_dataa, iss_datab, iss_imedext;
    logic [2:0]  iss_aluop;
    logic [1:0]  iss_shiftop;
    logic [4:0]  iss_regdest;
    logic        iss_writereg, iss_writeov, iss_unsig, iss_readmem, iss_writemem, iss_selwsource, iss_selimregb;
    logic        alu_done = 0, shift_done = 0, mem_done = 0, wb_valid = 0;
    logic [4:0]  wb_addr = 0;

    logic [31:0] regs [32];
    assign reg_iss_dataa = regs[iss_reg_addra];
    assign reg_iss_datab = regs[iss_reg_addrb];

    always #5 clock = ~clock;

    issue_stage dut (
        .clock(clock), .reset(reset),
        .i_id_op(id_op), .i_id_funct(id_funct),
        .i_id_addra(id_addra), .i_id_addrb(id_addrb), .i_id_regdest(id_regdest),
        .i_id_writereg(id_writereg), .i_id_writeov(id_writeov),
        .i_id_selalushift(id_selalushift), .i_id_selimregb(id_selimregb),
        .i_id_aluop(id_aluop), .i_id_shiftop(id_shiftop),
        .i_id_unsig(id_unsig), .i_id_readmem(id_readmem), .i_id_writemem(id_writemem),
        .i_id_selwsource(id_selwsource), .i_id_imedext(id_imedext),
        .o_iss_stall(iss_stall),
        .o_iss_reg_addra(iss_reg_addra), .o_iss_reg_addrb(iss_reg_addrb),
        .i_reg_iss_dataa(reg_iss_dataa), .i_reg_iss_datab(reg_iss_datab),
        .o_iss_alu_valid(iss_alu_valid), .o_iss_shift_valid(iss_shift_valid), .o_iss_mem_valid(iss_mem_valid),
        .o_iss_dataa(iss_dataa), .o_iss_datab(iss_datab), .o_iss_imedext(iss_imedext),
        .o_iss_aluop(iss_aluop), .o_iss_shiftop(iss_shiftop), .o_iss_regdest(iss_regdest),
        .o_iss_writereg(iss_writereg), .o_iss_writeov(iss_writeov), .o_iss_unsig(iss_unsig),
        .o_iss_readmem(iss_readmem), .o_iss_writemem(iss_writemem),
        .o_iss_selwsource(iss_selwsource), .o_iss_selimregb(iss_selimregb),
        .i_alu_done(alu_done), .i_shift_done(shift_done), .i_mem_done(mem_done),
        .i_wb_valid(wb_valid), .i_wb_addr(wb_addr)
    );

    typedef struct {
        logic [5:0]  op, fn;
        logic [4:0]  d, a, b;
        logic        sh, imm, rm, wm, wr, wov, uns, wsrc;
        logic [2:0]  aop;
        logic [1:0]  sop;
        logic [31:0] imed;
    } instr_t;

    typedef struct {
        instr_t     in;
        logic [2:0] exp_valid;
        logic [4:0] exp_regdest;
    } vec_t;

    int total = 0;
    int bad = 0;

    // Reference model state: which registers await writeback, which units are occupied
    bit           m_pend [32];
    bit           m_busy [3];
    logic [2:0]   m_valid;
    logic [112:0] m_pay;
    bit           g_stall;

    function automatic instr_t mk(input logic [5:0] op, input logic [5:0] fn,
                                  input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                                  input logic sh, input logic imm, input logic rm, input logic wm,
                                  input logic wr, input logic [2:0] aop, input logic [31:0] imed);
        instr_t x;
        x.op = op; x.fn = fn; x.d = d; x.a = a; x.b = b;
        x.sh = sh; x.imm = imm; x.rm = rm; x.wm = wm; x.wr = wr;
        x.wov = 0; x.uns = 0; x.wsrc = rm; x.aop = aop; x.sop = 0; x.imed = imed;
        return x;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t x;
        int k = $urandom_range(0, 3);
        x = mk(OP_RTYPE, FN_ADD, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               k == 1, 1'($urandom), k == 2, k == 3, (k != 3) && ($urandom_range(0, 3) != 0),
               3'($urandom), $urandom);
        x.wov = 1'($urandom); x.uns = 1'($urandom); x.sop = 2'($urandom); x.wsrc = 1'($urandom);
        return x;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic put(input instr_t x);
        id_op = x.op; id_funct = x.fn; id_regdest = x.d; id_addra = x.a; id_addrb = x.b;
        id_selalushift = x.sh; id_selimregb = x.imm; id_readmem = x.rm; id_writemem = x.wm;
        id_writereg = x.wr; id_writeov = x.wov; id_unsig = x.uns; id_selwsource = x.wsrc;
        id_aluop = x.aop; id_shiftop = x.sop; id_imedext = x.imed;
        #1;
    endtask

    function automatic int m_unit();
        return (id_readmem || id_writemem) ? 2 : id_selalushift ? 1 : 0;
    endfunction

    function automatic bit m_hazard();
        bit ua = !id_selalushift;
        bit ub = !id_selimregb || id_writemem || id_selalushift;
        return (ua && m_pend[id_addra]) || (ub && m_pend[id_addrb])
            || (id_writereg && m_pend[id_regdest]) || m_busy[m_unit()];
    endfunction

    function automatic logic [112:0] dut_pay();
        return {iss_dataa, iss_datab, iss_imedext, iss_aluop, iss_shiftop, iss_regdest, iss_writereg,
                iss_writeov, iss_unsig, iss_readmem, iss_writemem, iss_selwsource, iss_selimregb};
    endfunction

    function automatic logic [112:0] exp_pay();
        return {regs[id_addra], regs[id_addrb], id_imedext, id_aluop, id_shiftop, id_regdest, id_writereg,
                id_writeov, id_unsig, id_readmem, id_writemem, id_selwsource, id_selimregb};
    endfunction

    function automatic logic [2:0] dut_valid();
        return {iss_mem_valid, iss_shift_valid, iss_alu_valid};
    endfunction

    // One clock: apply pulses, check stall, advance model at the edge, check registered outputs
    task automatic tick(input bit ad, input bit sd, input bit md, input bit wv, input logic [4:0] wa);
        bit h;
        int u;
        logic [112:0] p;
        alu_done = ad; shift_done = sd; mem_done = md; wb_valid = wv; wb_addr = wa;
        #1;
        h = m_hazard();
        u = m_unit();
        p = exp_pay();
        g_stall = h;
        check("stall", 128'(iss_stall), 128'(h));
        @(posedge clock);
        m_valid = h ? 3'b000 : 3'(1 << u);
        if (!h) m_pay = p;
        if (wv) m_pend[wa] = 0;
        if (ad) m_busy[0] = 0;
        if (sd) m_busy[1] = 0;
        if (md) m_busy[2] = 0;
        if (!h) begin
            m_busy[u] = 1;
            if (id_writereg && id_regdest != 0) m_pend[id_regdest] = 1;
        end
        #1;
        check("valid", 128'(dut_valid()), 128'(m_valid));
        check("payload", 128'(dut_pay()), 128'(m_pay));
        alu_done = 0; shift_done = 0; mem_done = 0; wb_valid = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        #2;
        foreach (m_pend[i]) m_pend[i] = 0;
        foreach (m_busy[i]) m_busy[i] = 0;
        m_valid = 0;
        m_pay = 0;
        check("rst_stall", 128'(iss_stall), 128'(0));
        check("rst_valid", 128'(dut_valid()), 128'(0));
        check("rst_payload", 128'(dut_pay()), 128'(0));
        @(posedge clock);
        #1;
        reset = 1;
    endtask

    vec_t tbl [7];
    instr_t add3, nop;

    initial begin
        foreach (regs[i]) regs[i] = $urandom;
        regs[0] = 0;
        nop  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add3 = mk(OP_RTYPE, FN_ADD, 3, 1, 2, 0, 0, 0, 0, 1, 3'd2, 0);
        tbl[0] = '{add3, 3'b001, 5'd3};
        tbl[1] = '{mk(OP_RTYPE, FN_SLL, 3, 0, 3, 1, 1, 0, 0, 1, 0, 2), 3'b010, 5'd3};
        tbl[2] = '{mk(OP_LW, 0, 7, 1, 0, 0, 1, 1, 0, 1, 3'd2, 0), 3'b100, 5'd7};
        tbl[3] = '{mk(OP_SW, 0, 0, 2, 7, 0, 1, 0, 1, 0, 3'd2, 4), 3'b100, 5'd0};
        tbl[4] = '{nop, 3'b001, 5'd0};
        tbl[5] = '{mk(OP_ADDI, 0, 8, 9, 0, 0, 1, 0, 0, 1, 3'd2, 5), 3'b001, 5'd8};
        tbl[6] = '{mk(OP_RTYPE, FN_OR, 5, 0, 6, 0, 0, 0, 0, 1, 3'd1, 0), 3'b001, 5'd5};
        put(nop);
        do_reset();

        // Table: unit selection and payload from a clean scoreboard
        for (int i = 0; i < 7; i++) begin
            do_reset();
            put(tbl[i].in);
            tick(0, 0, 0, 0, 0);
            check("tbl_valid", 128'(dut_valid()), 128'(tbl[i].exp_valid));
            check("tbl_regdest", 128'(iss_regdest), 128'(tbl[i].exp_regdest));
        end

        // Reset mid-traffic, then add dispatches one cycle after release
        do_reset();
        put(add3);
        tick(0, 0, 0, 0, 0);
        put(mk(OP_RTYPE, FN_SUB, 4, 3, 5, 0, 0, 0, 0, 1, 3'd6, 0));
        tick(0, 0, 0, 0, 0);
        do_reset();
        put(add3);
        tick(0, 0, 0, 0, 0);
        check("t1_alu", 128'(dut_valid()), 128'(3'b001));

        // RAW on rs: sub waits for writeback of r3
        do_reset();
        put(add3);
        tick(0, 0, 0, 0, 0);
        put(mk(OP_RTYPE, FN_SUB, 4, 3, 5, 0, 0, 0, 0, 1, 3'd6, 0));
        tick(1, 0, 0, 0, 0);
        check("t2_stall_pend", 128'(iss_stall), 128'(1));
        tick(0, 0, 0, 1, 3);
        check("t2_unblock", 128'(iss_stall), 128'(0));
        check("t2_nostrobe", 128'(dut_valid()), 128'(0));
        tick(0, 0, 0, 0, 0);
        check("t2_alu", 128'(dut_valid()), 128'(3'b001));
        check("t2_rd", 128'(iss_regdest), 128'(4));

        // RAW on rt through writemem: sw waits for lw writeback and mem_done
        do_reset();
        put(tbl[2].in);
        tick(0, 0, 0, 0, 0);
        put(tbl[3].in);
        tick(0, 0, 1, 0, 0);
        check("t3_stall_pend", 128'(iss_stall), 128'(1));
        tick(0, 0, 0, 1, 7);
        check("t3_unblock", 128'(iss_stall), 128'(0));
        tick(0, 0, 0, 0, 0);
        check("t3_mem", 128'(dut_valid()), 128'(3'b100));
        check("t3_wm", 128'(iss_writemem), 128'(1));

        // Writeback and set of r3 in the same cycle: the set survives
        do_reset();
        put(add3);
        tick(0, 0, 0, 1, 3);
        put(tbl[1].in);
        check("t4_setwins", 128'(iss_stall), 128'(1));
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 3);
        tick(0, 0, 0, 0, 0);
        check("t4_shift", 128'(dut_valid()), 128'(3'b010));

        // Independent ALU ops: second waits for alu_done only
        do_reset();
        put(add3);
        tick(0, 0, 0, 0, 0);
        put(mk(OP_RTYPE, FN_ADD, 6, 4, 5, 0, 0, 0, 0, 1, 3'd2, 0));
        tick(0, 0, 0, 0, 0);
        check("t5_busy", 128'(iss_stall), 128'(1));
        tick(1, 0, 0, 0, 0);
        check("t5_unblock", 128'(iss_stall), 128'(0));
        tick(0, 0, 0, 0, 0);
        check("t5_alu", 128'(dut_valid()), 128'(3'b001));

        // Write to r0 never marks it pending
        do_reset();
        put(mk(OP_RTYPE, FN_ADD, 0, 1, 2, 0, 0, 0, 0, 1, 3'd2, 0));
        tick(0, 0, 0, 0, 0);
        put(tbl[6].in);
        tick(1, 0, 0, 0, 0);
        check("t6_r0", 128'(iss_stall), 128'(0));
        tick(0, 0, 0, 0, 0);
        check("t6_alu", 128'(dut_valid()), 128'(3'b001));

        // Random traffic: decode reloads only when the previous cycle did not stall
        do_reset();
        g_stall = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                g_stall = 0;
            end
            if (!g_stall) put(rnd_instr());
            tick($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
